// File: rtl/rib_timer_pkg.sv
// Shared definitions for the RIB timer: bus handshake levels, register
// offsets, CTRL bit positions and the slave FSM state encoding.
package rib_timer_pkg;

  localparam logic        RIB_ACK     = 1'b1;
  localparam logic        RIB_NACK    = 1'b0;
  localparam logic        RIB_REQ     = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Word offsets decoded from addr[3:2]
  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_PRESC = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_CMP   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 2;
  localparam int CTRL_AUTO = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rib_state_e;

  // The peripheral occupies a 16-byte window; anything above it is unmapped.
  function automatic logic addr_in_window(input logic [23:0] upper_bits);
    return upper_bits == 24'd0;
  endfunction

endpackage

// File: rtl/rib_slave_if.sv
// Responder side of the RIB request/ack handshake, reusable by any RIB
// peripheral with a 4-word register window.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for req_i; an access is accepted (and a write
//           | committed) on the edge that leaves this state
//   WAIT    | inserting WAIT_CYCLES wait states; bus inputs are frozen
//   RESP    | ack_o high for one cycle, data_o carries the read value
//
// wr_en/rd_en are single-cycle strobes. A write commits on the accept edge;
// read data is captured on the edge that enters RESP, so with wait states the
// latched address is used instead of the live bus.
module rib_slave_if
  import rib_timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rd_data,
  output logic        wr_en,
  output logic        rd_en,
  output logic [1:0]  reg_word,
  output logic        reg_hit,
  output logic [31:0] data_o,
  output logic        ack_o
);

  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  rib_state_e state;
  logic [3:0] wait_cnt;
  logic [1:0] word_q;
  logic       hit_q;
  logic       we_q;
  logic       accept;
  logic       resp_next;
  logic       live_hit;
  logic       unused_addr_bits;

  // Byte lane and the interconnect-owned upper nibble carry no meaning here.
  assign unused_addr_bits = ^{addr_i[31:28], addr_i[1:0]};

  assign live_hit  = addr_in_window(addr_i[27:4]);
  assign accept    = (state == ST_IDLE) && (req_i == RIB_REQ);
  assign resp_next = NO_WAIT ? accept
                             : ((state == ST_WAIT) && (wait_cnt == 4'd0));

  assign reg_word = (state == ST_IDLE) ? addr_i[3:2] : word_q;
  assign reg_hit  = (state == ST_IDLE) ? live_hit    : hit_q;
  assign wr_en    = accept && (we_i == WriteEnable);
  assign rd_en    = resp_next && ((state == ST_IDLE) ? (we_i != WriteEnable)
                                                     : (we_q != WriteEnable));

  // Handshake FSM with registered ack and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      word_q   <= 2'd0;
      hit_q    <= 1'b0;
      we_q     <= 1'b0;
      ack_o    <= RIB_NACK;
      data_o   <= ZeroWord;
    end else begin
      ack_o  <= resp_next ? RIB_ACK : RIB_NACK;
      data_o <= rd_en ? rd_data : ZeroWord;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            word_q   <= addr_i[3:2];
            hit_q    <= live_hit;
            we_q     <= we_i;
            wait_cnt <= WAIT_LOAD;
            state    <= NO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rib_timer.sv
// General-purpose RIB timer: prescaler, 32-bit up-counter, compare with
// auto-reload or one-shot behaviour, and a registered level interrupt.
module rib_timer
  import rib_timer_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int PRESC_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        int_sig_o
);

  logic               wr_en;
  logic               rd_en;
  logic [1:0]         reg_word;
  logic               reg_hit;
  logic [31:0]        rd_data;

  logic               ctrl_en;
  logic               ctrl_ie;
  logic               ctrl_pend;
  logic               ctrl_auto;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic [31:0]        count;
  logic [31:0]        cmp;

  logic               wr_ctrl;
  logic               wr_presc;
  logic               wr_count;
  logic               wr_cmp;
  logic               tick;
  logic               match;

  rib_slave_if #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_slave (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .reg_word (reg_word),
    .reg_hit  (reg_hit),
    .data_o   (data_o),
    .ack_o    (ack_o)
  );

  assign wr_ctrl  = wr_en && reg_hit && (reg_word == REG_CTRL);
  assign wr_presc = wr_en && reg_hit && (reg_word == REG_PRESC);
  assign wr_count = wr_en && reg_hit && (reg_word == REG_COUNT);
  assign wr_cmp   = wr_en && reg_hit && (reg_word == REG_CMP);

  // A match replaces the ordinary increment when the pre-tick count equals CMP.
  assign tick  = ctrl_en && (presc_cnt == presc);
  assign match = tick && (count == cmp);

  // Read mux; unmapped addresses read as zero
  always_comb begin
    rd_data = ZeroWord;
    if (rd_en && reg_hit) begin
      unique case (reg_word)
        REG_CTRL: begin
          rd_data[CTRL_EN]   = ctrl_en;
          rd_data[CTRL_IE]   = ctrl_ie;
          rd_data[CTRL_PEND] = ctrl_pend;
          rd_data[CTRL_AUTO] = ctrl_auto;
        end
        REG_PRESC: rd_data = 32'(presc);
        REG_COUNT: rd_data = count;
        REG_CMP:   rd_data = cmp;
        default:   rd_data = ZeroWord;
      endcase
    end
  end

  // CTRL: bus write of EN beats the one-shot clear, a match beats a PEND clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en   <= 1'b0;
      ctrl_ie   <= 1'b0;
      ctrl_pend <= 1'b0;
      ctrl_auto <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= data_i[CTRL_EN];
        ctrl_ie   <= data_i[CTRL_IE];
        ctrl_auto <= data_i[CTRL_AUTO];
      end else if (match && !ctrl_auto) begin
        ctrl_en <= 1'b0;
      end
      if (match)                               ctrl_pend <= 1'b1;
      else if (wr_ctrl && data_i[CTRL_PEND])   ctrl_pend <= 1'b0;
    end
  end

  // Prescaler reload register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           presc <= '0;
    else if (wr_presc) presc <= data_i[PRESC_W-1:0];
  end

  // Prescaler counter; parked at 0 while disabled so enabling restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                presc_cnt <= '0;
    else if (!ctrl_en || tick) presc_cnt <= '0;
    else                    presc_cnt <= presc_cnt + 1'b1;
  end

  // Main counter; a bus write overrides any tick on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= ZeroWord;
    end else if (wr_count) begin
      count <= data_i;
    end else if (match) begin
      if (ctrl_auto) count <= ZeroWord;
    end else if (tick) begin
      count <= count + 32'd1;
    end
  end

  // Compare register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cmp <= ZeroWord;
    else if (wr_cmp) cmp <= data_i;
  end

  // Registered interrupt level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) int_sig_o <= 1'b0;
    else     int_sig_o <= ctrl_pend & ctrl_ie;
  end

endmodule

// File: tb/tb_rib_timer.sv
// Directed bench for rib_timer: one instance without wait states and one
// with three, a register-access vector table, and hand-timed sequences for
// the timer and collision corner cases.
module tb_rib_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0;
  logic        req3 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] dat0, dat3;
  logic        ack0, ack3, int0, int3;

  int n_assert = 0;
  int n_fail   = 0;
  logic        ack_after;
  logic [31:0] dat_after;

  always #5 clk = ~clk;

  rib_timer #(.WAIT_CYCLES(0), .PRESC_W(16)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(dat0), .ack_o(ack0), .int_sig_o(int0)
  );

  rib_timer #(.WAIT_CYCLES(3), .PRESC_W(16)) dut3 (
    .clk(clk), .rst(rst), .req_i(req3), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(dat3), .ack_o(ack3), .int_sig_o(int3)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One access: accept on the next edge, wait (bounded) for ack, then one
  // more edge so the slave is back in IDLE.
  task automatic bus(input bit u3, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rdv,
                     output int lat, output bit tmo);
    we = w; addr = a; wdata = d;
    if (u3) req3 = 1'b1; else req0 = 1'b1;
    lat = 0; rdv = 32'h0; tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      req0 = 1'b0; req3 = 1'b0;
      lat++;
      if ((u3 ? ack3 : ack0) === 1'b1) begin
        rdv = u3 ? dat3 : dat0;
        tmo = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    ack_after = u3 ? ack3 : ack0;
    dat_after = u3 ? dat3 : dat0;
  endtask

  task automatic wr(input bit u3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; int lat; bit tmo;
    bus(u3, 1'b1, a, d, r, lat, tmo);
    check("wr_acked", {31'd0, tmo}, 32'd0);
  endtask

  task automatic rd(input bit u3, input logic [31:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] r; int lat; bit tmo;
    bus(u3, 1'b0, a, 32'h0, r, lat, tmo);
    check("rd_acked", {31'd0, tmo}, 32'd0);
    check(nm, r, exp);
  endtask

  // Asynchronous reset asserted mid-cycle, outputs must drop immediately.
  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_int0", {31'd0, int0}, 32'd0);
    check("rst_dat0", dat0, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Held request: acks at a fixed period, data only during ack.
  task automatic held(input bit u3, input int exp_first, input int period, input int exp_n);
    int first, last, n;
    logic a;
    logic [31:0] dd;
    first = -1; last = -1; n = 0;
    we = 1'b0; addr = 32'hC; wdata = 32'h0;
    if (u3) req3 = 1'b1; else req0 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      a  = u3 ? ack3 : ack0;
      dd = u3 ? dat3 : dat0;
      if (a === 1'b1) begin
        n++;
        check("held_data", dd, 32'h5);
        if (first < 0) first = i;
        else check("held_gap", 32'(i - last), 32'(period));
        last = i;
      end else begin
        check("held_data_idle", dd, 32'h0);
      end
    end
    req0 = 1'b0; req3 = 1'b0;
    check("held_first", 32'(first), 32'(exp_first));
    check("held_count", 32'(n), 32'(exp_n));
    idle(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int lat;
    bit tmo;
    int nack;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,          32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,          32'h0};
    vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,          32'h0};
    vecs[4]  = '{1'b1, 32'h0000_000C, 32'h5,          32'h0};
    vecs[5]  = '{1'b0, 32'h0000_000C, 32'h0,          32'h5};
    vecs[6]  = '{1'b1, 32'h0000_0004, 32'hFFFF_1234,  32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0004, 32'h0,          32'h1234};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFE,  32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,          32'hA};
    vecs[10] = '{1'b1, 32'h0000_0008, 32'h1234_5678,  32'h0};
    vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,          32'h1234_5678};
    vecs[12] = '{1'b0, 32'h0000_0040, 32'h0,          32'h0};
    vecs[13] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF,  32'h0};
    vecs[14] = '{1'b0, 32'h0000_000F, 32'h0,          32'h5};
    vecs[15] = '{1'b0, 32'h0000_0005, 32'h0,          32'h1234};
    vecs[16] = '{1'b0, 32'h0000_0008, 32'h0,          32'h1234_5678};
    vecs[17] = '{1'b0, 32'h0000_0000, 32'h0,          32'hA};
    vecs[18] = '{1'b0, 32'h0100_0008, 32'h0,          32'h0};
    vecs[19] = '{1'b1, 32'h0100_0000, 32'h1,          32'h0};
    vecs[20] = '{1'b0, 32'h0000_0000, 32'h0,          32'hA};

    #1;
    check("por_ack0", {31'd0, ack0}, 32'd0);
    check("por_dat0", dat0, 32'd0);
    check("por_int0", {31'd0, int0}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Register access table on the zero-wait instance
    for (int i = 0; i < NVEC; i++) begin
      bus(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, r, lat, tmo);
      check($sformatf("vec%0d_acked", i), {31'd0, tmo}, 32'd0);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
    end

    // Three wait states: ack four edges after accept, one cycle wide
    bus(1'b1, 1'b1, 32'hC, 32'h5, r, lat, tmo);
    check("w3_wr_latency", 32'(lat), 32'd4);
    check("w3_wr_ack_width", {31'd0, ack_after}, 32'd0);
    bus(1'b1, 1'b0, 32'hC, 32'h0, r, lat, tmo);
    check("w3_rd_latency", 32'(lat), 32'd4);
    check("w3_rd_data", r, 32'h5);
    check("w3_rd_ack_width", {31'd0, ack_after}, 32'd0);
    check("w3_rd_data_after", dat_after, 32'd0);

    held(1'b0, 1, 2, 8);
    held(1'b1, 4, 5, 3);

    // Auto-reload: PRESC=1, CMP=3, match on the 4th tick (8 edges after enable)
    do_reset();
    wr(1'b0, 32'h4, 32'h1);
    wr(1'b0, 32'hC, 32'h3);
    wr(1'b0, 32'h0, 32'hB);
    for (int k = 2; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (k == 8) check("auto_int_before", {31'd0, int0}, 32'd0);
      if (k == 9) check("auto_int_after", {31'd0, int0}, 32'd1);
    end
    rd(1'b0, 32'h8, 32'h0, "auto_count_reloaded");
    rd(1'b0, 32'h0, 32'hF, "auto_ctrl_pend");
    wr(1'b0, 32'h0, 32'hF);
    check("auto_int_cleared", {31'd0, int0}, 32'd0);
    idle(2);
    check("auto_int_rematch", {31'd0, int0}, 32'd1);

    // Reset in the middle of accesses on both instances
    we = 1'b0; addr = 32'hC; req0 = 1'b1; req3 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0; req3 = 1'b0;
    check("pre_rst_ack0", {31'd0, ack0}, 32'd1);
    check("pre_rst_dat0", dat0, 32'h3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack0", {31'd0, ack0}, 32'd0);
    check("mid_rst_dat0", dat0, 32'd0);
    check("mid_rst_int0", {31'd0, int0}, 32'd0);
    check("mid_rst_ack3", {31'd0, ack3}, 32'd0);
    check("mid_rst_dat3", dat3, 32'd0);
    check("mid_rst_int3", {31'd0, int3}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    nack = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (ack3 === 1'b1) nack++;
    end
    check("dropped_access_no_ack", 32'(nack), 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd(1'b0, 32'(k * 4), 32'h0, $sformatf("post_rst_reg%0d_w0", k));
      rd(1'b1, 32'(k * 4), 32'h0, $sformatf("post_rst_reg%0d_w3", k));
    end

    // One-shot: CMP=2, PRESC=0, match on the 3rd tick; COUNT holds, EN clears
    do_reset();
    wr(1'b0, 32'hC, 32'h2);
    wr(1'b0, 32'h0, 32'h3);
    idle(3);
    check("oneshot_int", {31'd0, int0}, 32'd1);
    rd(1'b0, 32'h8, 32'h2, "oneshot_count_hold");
    rd(1'b0, 32'h0, 32'h6, "oneshot_ctrl");

    // EN=1 write on the one-shot match edge keeps the timer enabled
    do_reset();
    wr(1'b0, 32'h4, 32'h3);
    wr(1'b0, 32'hC, 32'h2);
    wr(1'b0, 32'h0, 32'h3);
    idle(10);
    wr(1'b0, 32'h0, 32'h3);
    rd(1'b0, 32'h0, 32'h7, "collide_en_write_wins");

    // COUNT write on a tick edge
    do_reset();
    wr(1'b0, 32'h4, 32'h3);
    wr(1'b0, 32'hC, 32'hFFFF);
    wr(1'b0, 32'h0, 32'h1);
    idle(2);
    wr(1'b0, 32'h8, 32'h100);
    rd(1'b0, 32'h8, 32'h100, "collide_count_write_wins");

    // PEND clear on the match edge: the set wins
    do_reset();
    wr(1'b0, 32'hC, 32'h3);
    wr(1'b0, 32'h0, 32'h9);
    idle(2);
    wr(1'b0, 32'h0, 32'hD);
    rd(1'b0, 32'h0, 32'hD, "collide_pend_set_wins");

    // Wrap from 0xFFFFFFFF to 0 without a match, then the CMP=0 match
    do_reset();
    wr(1'b0, 32'h8, 32'hFFFF_FFFF);
    wr(1'b0, 32'h0, 32'h3);
    idle(1);
    check("wrap_no_pend", {31'd0, int0}, 32'd0);
    rd(1'b0, 32'h8, 32'h0, "wrap_count_zero");
    rd(1'b0, 32'h0, 32'h6, "wrap_then_match_ctrl");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rib_timer.md
Name: rib_timer

Overview:
- General-purpose timer that sits on one slave port of the RIB interconnect (e.g. slave 2).
- It implements the responder side of the RIB request/ack handshake. It provides a programmable prescaler, a 32-bit up-counter, a compare register and a level interrupt to the core's interrupt input.
- Register accesses are synchronous, with a registered ack and optional wait states.

Parameters:
- WAIT_CYCLES, 0, extra wait cycles inserted between request accept and ack (0..15).
- PRESC_W, 16, width of prescaler reload and prescaler counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req_i  in  1  RIB access request from the interconnect.
- we_i  in  1  RIB write enable (1 = write).
- addr_i  in  32  RIB address; upper nibble is already zeroed by the interconnect.
- data_i  in  32  RIB write data.
- data_o  out  32  RIB read data; valid while ack_o = 1.
- ack_o  out  1  RIB access-complete strobe.
- int_sig_o  out  1  timer interrupt, level, active-high.

Behaviour:
- Register map, decoded from addr_i[3:2]; addr_i[1:0] are ignored:
  - 0x0: CTRL. Bit0 EN; bit1 IE; bit2 PEND (read 1 = pending, write 1 = clear); bit3 AUTO (1 = auto-reload, 0 = one-shot). Bits 31:4 read 0.
  - 0x4: PRESC. Bits PRESC_W-1:0; upper bits read 0.
  - 0x8: COUNT.
  - 0xC: CMP.
- Any address with addr_i[27:4] != 0: read returns 0, write is ignored, and the access is still acked.
- Reset: ack_o = 0, data_o = 0, int_sig_o = 0, all registers 0, prescaler counter 0, FSM in IDLE.
- Bus FSM, states IDLE, WAIT, RESP:
  - IDLE with req_i = 1: the access is accepted at this edge. A write commits to the register at this same edge. Read data is sampled into data_o at the edge that enters RESP.
  - From IDLE: go to RESP if WAIT_CYCLES = 0, otherwise go to WAIT.
  - WAIT: a down-counter loaded with WAIT_CYCLES-1; go to RESP when it reaches 0. addr_i, we_i and data_i are not re-sampled in WAIT.
  - RESP: ack_o = 1 for exactly one cycle and data_o holds the read value; then return to IDLE. data_o returns to 0 in every state other than RESP.
  - Latency: req accepted at edge N gives ack high during cycle N+1+WAIT_CYCLES.
  - If req_i is still high in IDLE after RESP, it is a new access. A continuously held request is therefore acked once every 2+WAIT_CYCLES cycles.
  - A write to CTRL is visible to a read whose accept edge is one or more cycles later.
- Timer:
  - While EN = 1, the prescaler counts 0..PRESC. Reaching PRESC produces a tick and wraps the prescaler to 0. PRESC = 0 gives a tick every cycle.
  - On a tick, COUNT is incremented. If the value before the increment equals CMP, the tick is a match instead.
  - On a match: PEND is set. If AUTO = 1, COUNT goes to 0. If AUTO = 0, COUNT holds and EN is cleared.
  - Without a match, COUNT wraps 0xFFFFFFFF -> 0 and does not set PEND.
  - When EN = 0, the prescaler is held at 0 and COUNT holds.
  - Writing EN 0 -> 1 restarts the prescaler at 0.
- Simultaneous events:
  - A bus write to COUNT or PRESC on the same edge as a tick: the bus write wins.
  - A PEND set (match) on the same edge as a PEND clear write: set wins.
  - A one-shot EN clear on the same edge as a bus write of EN = 1: the bus write wins.
- int_sig_o is registered: int_sig_o = PEND & IE, visible one cycle after either changes.
- Asynchronous reset mid-access: the FSM goes to IDLE, ack_o = 0, and the pending access is dropped with no ack.

Decomposition:
- Shared defines (already-shared macro file): RIB_ACK / RIB_NACK, RIB_REQ / RIB_NREQ, WriteEnable, ZeroWord.
- Timer-local defines (new include or localparams): register offsets (REG_CTRL, REG_PRESC, REG_COUNT, REG_CMP), CTRL bit indices, FSM state encodings.
- One natural sub-module: rib_slave_if. It holds the IDLE/WAIT/RESP FSM, the wait counter and ack generation, and emits a one-cycle wr_en/rd_en strobe plus register address. It is reusable for future RIB peripherals. Register file and timer core stay in rib_timer.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> ack_o, data_o and int_sig_o all 0 immediately; reads of all four registers return 0.
- Handshake latency: with WAIT_CYCLES = 0 and then 3, write CMP = 0x5 and read it back -> ack high exactly one cycle, at N+1 and then N+4. Read data is 0x00000005. A held req_i gives acks every 2 and then 5 cycles.
- Auto-reload: PRESC = 1, CMP = 3, CTRL = 0xB (EN, IE, AUTO) -> COUNT runs 0,1,2,3 at 2-cycle ticks then returns to 0. PEND is set and int_sig_o goes high one cycle later. Writing CTRL = 0xF (PEND = 1 written with EN, IE, AUTO kept) clears int_sig_o.
- One-shot: CTRL = 0x3, CMP = 2 -> on the match COUNT holds at 2, EN reads 0, PEND = 1.
- Collisions: force a COUNT write (0x100) on the tick edge -> COUNT = 0x100. Force a PEND clear on the match edge -> PEND stays 1.
- Unmapped address: read 0x40 returns 0x00000000 with ack; write 0x40 = 0xFFFFFFFF acks and leaves all registers unchanged. COUNT = 0xFFFFFFFF with CMP = 0 and PRESC = 0 wraps to 0 on the next tick without setting PEND.
